// File: rtl/input_conditioner.sv
// Synchronizes and debounces two buttons and eight switches, producing clean
// levels plus single-cycle strobes that stay quiet until each channel is armed.
module input_conditioner #(
    parameter int DB_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BTN1_in,
    input  logic       BTN6_in,
    input  logic       SW7_in,
    input  logic [6:0] SW_in,
    output logic       BTN1_pulse,
    output logic       BTN6_pulse,
    output logic       SW7_level,
    output logic       SW7_rise,
    output logic [6:0] SW_level,
    output logic       SW_change
);

    localparam int          NCH  = 10;
    localparam logic [15:0] LAST = 16'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } ch_state_t;

    // Channel order: 0 BTN1, 1 BTN6, 2 SW7, 3..9 SW[0..6]
    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] sync1_r;
    logic [NCH-1:0] sync2_r;
    logic [NCH-1:0] hi_s;
    logic [NCH-1:0] armed_s;
    logic [NCH-1:0] level_r;
    logic [NCH-1:0] armed_dly_r;
    logic [NCH-1:0] rise_s;
    logic [NCH-1:0] edge_s;

    assign raw_s = {SW_in, SW7_in, BTN6_in, BTN1_in};

    // Two-flop synchronizer for every raw input bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_t   state_r, state_s;
        logic [15:0] cnt_r, cnt_s;
        logic        armed_r, armed_nx_s;
        logic        s;

        assign s = sync2_r[i];

        // Channel state, counter and armed flag
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= STABLE_LO;
                cnt_r   <= 16'd0;
                armed_r <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                armed_r <= armed_nx_s;
            end
        end

        // Debounce next-state; an unarmed idle-low channel reuses the counter to arm
        always_comb begin
            state_s    = state_r;
            cnt_s      = cnt_r;
            armed_nx_s = armed_r;
            case (state_r)
                STABLE_LO: begin
                    if (s) begin
                        state_s = WAIT_HI;
                        cnt_s   = 16'd1;
                    end else if (!armed_r) begin
                        if (cnt_r == LAST) begin
                            armed_nx_s = 1'b1;
                            cnt_s      = 16'd0;
                        end else begin
                            cnt_s = cnt_r + 16'd1;
                        end
                    end else begin
                        cnt_s = 16'd0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_s = STABLE_LO;
                        cnt_s   = 16'd0;
                    end else if (cnt_r == LAST) begin
                        state_s    = STABLE_HI;
                        cnt_s      = 16'd0;
                        armed_nx_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_s = WAIT_LO;
                        cnt_s   = 16'd1;
                    end else begin
                        cnt_s = 16'd0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_s = STABLE_HI;
                        cnt_s   = 16'd0;
                    end else if (cnt_r == LAST) begin
                        state_s    = STABLE_LO;
                        cnt_s      = 16'd0;
                        armed_nx_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_s = STABLE_LO;
                    cnt_s   = 16'd0;
                end
            endcase
        end

        assign hi_s[i]    = (state_r == STABLE_HI) || (state_r == WAIT_LO);
        assign armed_s[i] = armed_r;
    end

    // armed_dly_r lines up with level_r, so the acceptance that arms a channel cannot strobe
    assign rise_s = hi_s & ~level_r & armed_dly_r;
    assign edge_s = (hi_s ^ level_r) & armed_dly_r;

    // Registered levels and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r     <= '0;
            armed_dly_r <= '0;
            BTN1_pulse  <= 1'b0;
            BTN6_pulse  <= 1'b0;
            SW7_rise    <= 1'b0;
            SW_change   <= 1'b0;
        end else begin
            level_r     <= hi_s;
            armed_dly_r <= armed_s;
            BTN1_pulse  <= rise_s[0];
            BTN6_pulse  <= rise_s[1];
            SW7_rise    <= rise_s[2];
            SW_change   <= |edge_s[9:3];
        end
    end

    assign SW7_level = level_r[2];
    assign SW_level  = level_r[9:3];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DB_CYCLES=4; expected values are hand-derived.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       BTN1_in, BTN6_in, SW7_in;
    logic [6:0] SW_in;
    logic       BTN1_pulse, BTN6_pulse, SW7_level, SW7_rise, SW_change;
    logic [6:0] SW_level;

    int errors = 0;
    int checks = 0;
    int n_btn1 = 0, n_btn6 = 0, n_rise = 0, n_chg = 0;
    int base1, base6, baser, basec;

    input_conditioner #(.DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .BTN1_in(BTN1_in), .BTN6_in(BTN6_in), .SW7_in(SW7_in), .SW_in(SW_in),
        .BTN1_pulse(BTN1_pulse), .BTN6_pulse(BTN6_pulse),
        .SW7_level(SW7_level), .SW7_rise(SW7_rise),
        .SW_level(SW_level), .SW_change(SW_change)
    );

    always #5 clk = ~clk;

    // Strobe counters sampled away from the active edge
    always @(negedge clk) begin
        if (BTN1_pulse) n_btn1++;
        if (BTN6_pulse) n_btn6++;
        if (SW7_rise)   n_rise++;
        if (SW_change)  n_chg++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; BTN1_in = 1'b0; BTN6_in = 1'b0; SW7_in = 1'b0; SW_in = 7'h00;
        #23;
        check("rst_outputs", {26'd0, BTN1_pulse, BTN6_pulse, SW7_level, SW7_rise, SW_change, 1'b0}, 32'd0);
        check("rst_sw_level", {25'd0, SW_level}, 32'd0);
        rst_n = 1'b1;
        step(20);

        // Single press: edge 0 is the first edge after the input change
        BTN1_in = 1'b1;
        step(6);
        check("btn1_edge5", {31'd0, BTN1_pulse}, 32'd0);
        step(1);
        check("btn1_edge6", {31'd0, BTN1_pulse}, 32'd1);
        step(1);
        check("btn1_edge7", {31'd0, BTN1_pulse}, 32'd0);
        step(20);
        BTN1_in = 1'b0;
        step(20);
        check("btn1_one_strobe", n_btn1, 32'd1);

        // Short glitches never accepted
        for (int k = 0; k < 5; k++) begin
            BTN6_in = 1'b1; step(3);
            BTN6_in = 1'b0; step(3);
        end
        step(10);
        check("btn6_glitch", n_btn6, 32'd0);

        // Simultaneous presses
        BTN1_in = 1'b1; BTN6_in = 1'b1;
        step(7);
        check("both_btn1", {31'd0, BTN1_pulse}, 32'd1);
        check("both_btn6", {31'd0, BTN6_pulse}, 32'd1);
        step(1);
        check("both_after", {30'd0, BTN1_pulse, BTN6_pulse}, 32'd0);
        BTN1_in = 1'b0; BTN6_in = 1'b0;
        step(20);
        check("both_counts", {n_btn1[15:0], n_btn6[15:0]}, {16'd2, 16'd1});

        // Multi-bit switch change gives a single strobe
        basec = n_chg;
        SW_in = 7'h55;
        step(6);
        check("sw_level_edge5", {25'd0, SW_level}, 32'h00);
        step(1);
        check("sw_level_edge6", {25'd0, SW_level}, 32'h55);
        check("sw_change_edge6", {31'd0, SW_change}, 32'd1);
        step(10);
        check("sw_change_count", n_chg - basec, 32'd1);

        // Reset mid-count with BTN1 at counter=2; SW7 already high through reset
        BTN1_in = 1'b1;
        step(4);
        SW7_in = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_sw", {25'd0, SW_level}, 32'd0);
        check("async_rst_misc", {27'd0, BTN1_pulse, BTN6_pulse, SW7_level, SW7_rise, SW_change}, 32'd0);
        #10;
        base1 = n_btn1; baser = n_rise; basec = n_chg;
        rst_n = 1'b1;
        step(6);
        check("sw7_post_rst_5", {31'd0, SW7_level}, 32'd0);
        step(1);
        check("sw7_post_rst_6", {31'd0, SW7_level}, 32'd1);
        check("sw_post_rst_6", {25'd0, SW_level}, 32'h55);
        step(20);
        check("unarmed_btn1", n_btn1 - base1, 32'd0);
        check("unarmed_sw7", n_rise - baser, 32'd0);
        check("unarmed_sw", n_chg - basec, 32'd0);

        // After arming, SW7 toggle gives exactly one rise
        SW7_in = 1'b0;
        step(15);
        check("sw7_low_level", {31'd0, SW7_level}, 32'd0);
        check("sw7_fall_norise", n_rise - baser, 32'd0);
        SW7_in = 1'b1;
        step(15);
        check("sw7_high_level", {31'd0, SW7_level}, 32'd1);
        check("sw7_one_rise", n_rise - baser, 32'd1);

        // All switch bits flip at once: one strobe
        basec = n_chg;
        SW_in = 7'h2A;
        step(15);
        check("sw_flip_level", {25'd0, SW_level}, 32'h2A);
        check("sw_flip_count", n_chg - basec, 32'd1);
        BTN1_in = 1'b0;
        step(15);
        check("btn1_release_norm", n_btn1 - base1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
